rs_syndrome_ctrl: RTL and testbench
===================================

RS_SYNDROME_CTRL -- requirements
Module: rs_syndrome_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 4, symbol width; only 4 supported (GF(2^4), primitive polynomial x^4+x+1, alpha=4'h2).
REQ-002 Parameter N_SYM, default 15, codeword length in symbols.
REQ-003 Parameter N_SYN, default 6, number of syndromes (S1..S6).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clr  input  1  synchronous abort; discards the current codeword.
REQ-007 in_valid  input  1  in_data holds a valid symbol.
REQ-008 in_ready  output  1  block accepts a symbol this cycle.
REQ-009 in_data  input  DATA_WIDTH  received symbol, highest-degree coefficient (r14) first.
REQ-010 syn_valid  output  1  syndrome set complete and held stable.
REQ-011 syn_ready  input  1  consumer takes the syndrome set.
REQ-012 syn_data  output  N_SYN*DATA_WIDTH  packed syndromes, S_j at bits [4j-1:4j-4].
REQ-013 syn_nonzero  output  1  OR of all syndrome bits; valid only while syn_valid=1.

Function
REQ-014 State machine SHALL have two states: ACC (accumulating) and DONE (holding result).
REQ-015 In ACC, in_ready SHALL be 1 and syn_valid 0; in DONE, in_ready SHALL be 0 and syn_valid 1.
REQ-016 Symbol accepted when in_valid & in_ready; no other condition advances state.
REQ-017 On each accepted symbol r, every accumulator SHALL update S_j <= (S_j * alpha^j) XOR r (Horner), GF multiply by constant, addition plain XOR.
REQ-018 4-bit symbol counter SHALL increment per accepted symbol, range 0..N_SYM-1.
REQ-019 Accepting the symbol at count N_SYM-1 SHALL move ACC->DONE and reset the counter to 0; syn_valid asserts the next cycle (latency 1 cycle after last symbol).
REQ-020 syn_data and syn_nonzero SHALL stay constant throughout DONE.
REQ-021 In DONE, syn_valid & syn_ready SHALL clear all accumulators to 0 and return to ACC the following cycle; no symbol accepted in that cycle.
REQ-022 Missing in_valid cycles (bubbles) SHALL not alter accumulators or counter.
REQ-023 clr=1 in any state SHALL clear accumulators and counter and force ACC next cycle; clr has priority over input and output handshakes in the same cycle.
REQ-024 syn_ready while in ACC SHALL be ignored.
REQ-025 Counter SHALL never exceed N_SYM-1; no wrap to 15 possible.

Reset
REQ-026 While rst=1: state=ACC, counter=0, all accumulators=0, in_ready=0, syn_valid=0, syn_data=0, syn_nonzero=0.
REQ-027 in_ready SHALL go 1 on the first rising clk after rst deasserts.
REQ-028 Reset asserted mid-codeword or in DONE SHALL discard all partial/held results immediately (asynchronously).

Verification
REQ-029 15 zero symbols, syn_ready=1 -> one cycle after 15th symbol syn_valid=1, syn_data=24'h000000, syn_nonzero=0; ACC next cycle.
REQ-030 r14=4'h1 (first symbol), rest 0 -> S1..S6 = 9,13,15,14,7,10; syn_data=24'hA7EFD9, syn_nonzero=1.
REQ-031 r0=4'h1 (last symbol), rest 0 -> all S_j=1, syn_data=24'h111111.
REQ-032 Same as REQ-030 with in_valid toggling 1/0 every cycle and syn_ready held 0 for 5 cycles -> identical syn_data, held stable all 5 cycles, in_ready=0 throughout DONE.
REQ-033 clr pulsed after 7 symbols, then 15 zero symbols -> syn_data=0 (prior symbols discarded); clr coinciding with in_valid -> symbol dropped, counter=0.
REQ-034 rst pulsed asynchronously between clock edges in DONE -> syn_valid drops without a clk edge; next full codeword of REQ-031 yields 24'h111111.

Source files
------------

// File: rtl/rs_syndrome_ctrl.sv
// rtl/rs_syndrome_ctrl.sv - Reed-Solomon GF(2^4) syndrome accumulator with stream handshakes
// Horner-evaluates S1..S_N_SYN over one codeword and holds the set until the consumer takes it.
module rs_syndrome_ctrl #(
   parameter int DATA_WIDTH = 4,
   parameter int N_SYM      = 15,
   parameter int N_SYN      = 6
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_clr,
   input  logic                          i_in_valid,
   output logic                          o_in_ready,
   input  logic [DATA_WIDTH-1:0]         i_in_data,
   output logic                          o_syn_valid,
   input  logic                          i_syn_ready,
   output logic [N_SYN*DATA_WIDTH-1:0]   o_syn_data,
   output logic                          o_syn_nonzero
);

   typedef enum logic {S_ACC, S_DONE} state_t;

   localparam logic [DATA_WIDTH-1:0] POLY = DATA_WIDTH'(3);
   localparam logic [3:0]            LAST = 4'(N_SYM - 1);

   state_t                          r_state;
   state_t                          w_state_next;
   logic                            r_run;
   logic [3:0]                      r_cnt;
   logic [N_SYN*DATA_WIDTH-1:0]     r_syn;
   logic [N_SYN*DATA_WIDTH-1:0]     w_syn_horner;
   logic                            w_accept;
   logic                            w_release;

   // Multiply by alpha^n: n successive shifts reduced by x^4+x+1.
   function automatic logic [DATA_WIDTH-1:0] gf_mul_pow(input logic [DATA_WIDTH-1:0] a,
                                                         input int n);
      logic [DATA_WIDTH-1:0] v;
      v = a;
      for (int i = 0; i < N_SYN; i++) begin
         if (i < n) begin
            v = {v[DATA_WIDTH-2:0], 1'b0} ^ (v[DATA_WIDTH-1] ? POLY : '0);
         end
      end
      return v;
   endfunction

   assign w_accept  = i_in_valid & o_in_ready;
   assign w_release = o_syn_valid & i_syn_ready;

   always_comb begin
      w_syn_horner = '0;
      for (int j = 0; j < N_SYN; j++) begin
         w_syn_horner[DATA_WIDTH*j +: DATA_WIDTH] =
            gf_mul_pow(r_syn[DATA_WIDTH*j +: DATA_WIDTH], j + 1) ^ i_in_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_ACC;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (i_clr) begin
         w_state_next = S_ACC;
      end else begin
         case (r_state)
            S_ACC:   if (w_accept && r_cnt == LAST) w_state_next = S_DONE;
            S_DONE:  if (w_release) w_state_next = S_ACC;
            default: w_state_next = S_ACC;
         endcase
      end
   end

   always_comb begin
      o_in_ready    = r_run & (r_state == S_ACC);
      o_syn_valid   = (r_state == S_DONE);
      o_syn_data    = r_syn;
      o_syn_nonzero = |r_syn;
   end

   // Holds in_ready low until the first edge after reset is released.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_syn <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
         r_syn <= '0;
      end else if (w_accept) begin
         r_syn <= w_syn_horner;
         r_cnt <= (r_cnt == LAST) ? 4'd0 : r_cnt + 4'd1;
      end else if (w_release) begin
         r_syn <= '0;
      end
   end

endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// tb/tb_rs_syndrome_ctrl.sv - directed table-driven bench for rs_syndrome_ctrl
module tb_rs_syndrome_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_data;
   logic        syn_valid;
   logic        syn_ready;
   logic [23:0] syn_data;
   logic        syn_nonzero;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      string       name;
      logic [59:0] cw;
      logic [23:0] exp_syn;
      logic        exp_nz;
   } vec_t;

   vec_t vecs[6];

   rs_syndrome_ctrl #(.DATA_WIDTH(4), .N_SYM(15), .N_SYN(6)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_clr         (clr),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_in_data     (in_data),
      .o_syn_valid   (syn_valid),
      .i_syn_ready   (syn_ready),
      .o_syn_data    (syn_data),
      .o_syn_nonzero (syn_nonzero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sym(input logic [3:0] d);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && t < 50) begin
         tick();
         t++;
      end
      if (t >= 50) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      tick();
      in_valid = 1'b0;
      in_data  = 4'h0;
   endtask

   task automatic send_cw(input logic [59:0] cw, input bit bubbles);
      for (int i = 14; i >= 0; i--) begin
         if (bubbles && i != 14) tick();
         send_sym(cw[4*i +: 4]);
      end
   endtask

   task automatic take_result(input string name);
      syn_ready = 1'b1;
      tick();
      syn_ready = 1'b0;
      chk({name, "_back_acc_valid"}, {63'd0, syn_valid}, 64'd0);
      chk({name, "_back_acc_ready"}, {63'd0, in_ready}, 64'd1);
      chk({name, "_cleared"}, {40'd0, syn_data}, 64'd0);
   endtask

   initial begin
      vecs[0] = '{"zeros",   60'h000000000000000, 24'h000000, 1'b0};
      vecs[1] = '{"r14_one", 60'h100000000000000, 24'hA7EFD9, 1'b1};
      vecs[2] = '{"r0_one",  60'h000000000000001, 24'h111111, 1'b1};
      vecs[3] = '{"r1_one",  60'h000000000000010, 24'hC63842, 1'b1};
      vecs[4] = '{"all_one", 60'h111111111111111, 24'h000000, 1'b0};
      vecs[5] = '{"r14_r0",  60'h100000000000001, 24'hB6FEC8, 1'b1};

      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 4'h0; syn_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",    {63'd0, in_ready},    64'd0);
      chk("rst_syn_valid",   {63'd0, syn_valid},   64'd0);
      chk("rst_syn_data",    {40'd0, syn_data},    64'd0);
      chk("rst_syn_nonzero", {63'd0, syn_nonzero}, 64'd0);
      rst = 1'b0;
      #1;
      chk("pre_edge_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      chk("post_edge_in_ready", {63'd0, in_ready}, 64'd1);

      for (int v = 0; v < 6; v++) begin
         send_cw(vecs[v].cw, 1'b0);
         chk({vecs[v].name, "_syn_valid"}, {63'd0, syn_valid},   64'd1);
         chk({vecs[v].name, "_in_ready"},  {63'd0, in_ready},    64'd0);
         chk({vecs[v].name, "_syn_data"},  {40'd0, syn_data},    {40'd0, vecs[v].exp_syn});
         chk({vecs[v].name, "_nonzero"},   {63'd0, syn_nonzero}, {63'd0, vecs[v].exp_nz});
         take_result(vecs[v].name);
      end

      // Bubbles on input, consumer stalls 5 cycles while in_valid is held high.
      send_cw(60'h100000000000000, 1'b1);
      in_valid = 1'b1;
      in_data  = 4'hF;
      for (int c = 0; c < 5; c++) begin
         chk("stall_syn_valid", {63'd0, syn_valid}, 64'd1);
         chk("stall_in_ready",  {63'd0, in_ready},  64'd0);
         chk("stall_syn_data",  {40'd0, syn_data},  64'h0000_0000_00A7_EFD9);
         tick();
      end
      in_valid = 1'b0;
      in_data  = 4'h0;
      take_result("stall");

      // Abort mid-codeword; the symbol presented alongside clr must be dropped.
      for (int i = 0; i < 7; i++) send_sym(4'h1);
      clr = 1'b1; in_valid = 1'b1; in_data = 4'h5;
      tick();
      clr = 1'b0; in_valid = 1'b0; in_data = 4'h0;
      chk("clr_syn_data", {40'd0, syn_data}, 64'd0);
      chk("clr_in_ready", {63'd0, in_ready}, 64'd1);
      send_cw(60'h000000000000001, 1'b0);
      chk("clr_then_r0_valid", {63'd0, syn_valid}, 64'd1);
      chk("clr_then_r0_data",  {40'd0, syn_data},  64'h0000_0000_0011_1111);
      take_result("clr_then_r0");

      // clr in DONE beats a concurrent syn_ready and discards the held set.
      send_cw(60'h100000000000000, 1'b0);
      clr = 1'b1; syn_ready = 1'b1;
      tick();
      clr = 1'b0; syn_ready = 1'b0;
      chk("clr_done_valid", {63'd0, syn_valid}, 64'd0);
      chk("clr_done_ready", {63'd0, in_ready},  64'd1);
      chk("clr_done_data",  {40'd0, syn_data},  64'd0);
      send_cw(60'h000000000000001, 1'b0);
      chk("after_clr_done_data", {40'd0, syn_data}, 64'h0000_0000_0011_1111);
      take_result("after_clr_done");

      // Asynchronous reset in DONE between clock edges.
      send_cw(60'h100000000000000, 1'b0);
      chk("pre_arst_valid", {63'd0, syn_valid}, 64'd1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_syn_valid", {63'd0, syn_valid}, 64'd0);
      chk("arst_syn_data",  {40'd0, syn_data},  64'd0);
      chk("arst_in_ready",  {63'd0, in_ready},  64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      send_cw(60'h000000000000001, 1'b0);
      chk("post_arst_valid", {63'd0, syn_valid}, 64'd1);
      chk("post_arst_data",  {40'd0, syn_data},  64'h0000_0000_0011_1111);
      take_result("post_arst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
